// File: rtl/hash_lut_cfg_ctrl.sv
// hash_lut_cfg_ctrl: sequences reconfiguration of the hash LUT bank.
// Drains in-flight lookups, then clears every LUT bit with the config strobe high.
// Next it forwards host bit-writes and finally returns the bank to lookup mode.
// Optional feature macro: HASH_LUT_CTRL_STATS_EN adds wr_cnt_o, a saturating count of
// accepted in-range host writes since the last clear.
module hash_lut_cfg_ctrl #(
    parameter int unsigned AMM_LUT_ADDR_W = 32,
    parameter int unsigned AMM_LUT_DATA_W = 32,
    parameter int unsigned MEM_BLOCKS_CNT = 2,
    parameter int unsigned MEM_BLOCKS_W   = 13,
    parameter int unsigned DRAIN_CYCLES   = 2
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      cfg_start_i,
    input  logic                      cfg_commit_i,
    input  logic [AMM_LUT_ADDR_W-1:0] host_lut_address_i,
    input  logic                      host_lut_write_i,
    input  logic [AMM_LUT_DATA_W-1:0] host_lut_writedata_i,
    output logic                      host_lut_waitrequest_o,
    input  logic                      lookup_busy_i,
    output logic                      lookup_hold_o,
    output logic                      lut_config_o,
    output logic [AMM_LUT_ADDR_W-1:0] lut_address_o,
    output logic                      lut_write_o,
    output logic [AMM_LUT_DATA_W-1:0] lut_writedata_o,
    output logic                      lut_valid_o,
    output logic                      addr_err_o,
    output logic [2:0]                state_o
`ifdef HASH_LUT_CTRL_STATS_EN
    ,
    output logic [31:0]               wr_cnt_o
`endif
);

    localparam int unsigned TOTAL  = MEM_BLOCKS_CNT << MEM_BLOCKS_W;
    localparam int unsigned CNT_W  = $clog2(TOTAL) + 1;
    localparam int unsigned IDLE_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_CLEAR = 3'd2,
        ST_LOAD  = 3'd3,
        ST_REL0  = 3'd4,
        ST_REL1  = 3'd5
    } state_t;

    state_t                    r_state,           w_nxt_state;
    logic [CNT_W-1:0]          r_clr_cnt,         w_nxt_clr_cnt;
    logic [IDLE_W-1:0]         r_idle_cnt,        w_nxt_idle_cnt;
    logic                      r_lut_write,       w_nxt_lut_write;
    logic [AMM_LUT_ADDR_W-1:0] r_lut_address,     w_nxt_lut_address;
    logic [AMM_LUT_DATA_W-1:0] r_lut_writedata,   w_nxt_lut_writedata;
    logic                      r_lut_config,      w_nxt_lut_config;
    logic                      r_lookup_hold,     w_nxt_lookup_hold;
    logic                      r_waitreq,         w_nxt_waitreq;
    logic                      r_lut_valid,       w_nxt_lut_valid;
    logic                      r_addr_err,        w_nxt_addr_err;
    logic                      w_accept;
    logic                      w_in_range;

    // A host write is taken only in LOAD while waitrequest is low
    assign w_accept   = (r_state == ST_LOAD) && host_lut_write_i && !r_waitreq;
    assign w_in_range = host_lut_address_i < AMM_LUT_ADDR_W'(TOTAL);

    // Next-state, datapath and output decode; outputs follow the next state so they align with it
    always_comb begin
        w_nxt_state         = r_state;
        w_nxt_clr_cnt       = r_clr_cnt;
        w_nxt_idle_cnt      = r_idle_cnt;
        w_nxt_lut_write     = 1'b0;
        w_nxt_lut_address   = r_lut_address;
        w_nxt_lut_writedata = r_lut_writedata;
        w_nxt_lut_valid     = r_lut_valid;
        w_nxt_addr_err      = r_addr_err;
        w_nxt_lut_config    = 1'b0;
        w_nxt_lookup_hold   = 1'b1;
        w_nxt_waitreq       = 1'b1;

        case (r_state)
            ST_RUN: begin
                if (cfg_start_i) begin
                    w_nxt_state     = ST_DRAIN;
                    w_nxt_idle_cnt  = '0;
                    w_nxt_lut_valid = 1'b0;
                    w_nxt_addr_err  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (lookup_busy_i) begin
                    w_nxt_idle_cnt = '0;
                end else if (r_idle_cnt == IDLE_W'(DRAIN_CYCLES - 1)) begin
                    w_nxt_state    = ST_CLEAR;
                    w_nxt_idle_cnt = '0;
                    w_nxt_clr_cnt  = '0;
                end else begin
                    w_nxt_idle_cnt = r_idle_cnt + IDLE_W'(1);
                end
            end
            ST_CLEAR: begin
                w_nxt_lut_write     = 1'b1;
                w_nxt_lut_address   = AMM_LUT_ADDR_W'(r_clr_cnt);
                w_nxt_lut_writedata = '0;
                w_nxt_clr_cnt       = r_clr_cnt + CNT_W'(1);
                if (r_clr_cnt == CNT_W'(TOTAL - 1)) begin
                    w_nxt_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_in_range) begin
                        w_nxt_lut_write     = 1'b1;
                        w_nxt_lut_address   = host_lut_address_i;
                        w_nxt_lut_writedata = host_lut_writedata_i;
                    end else begin
                        w_nxt_addr_err = 1'b1;
                    end
                end
                if (cfg_commit_i) begin
                    w_nxt_state = ST_REL0;
                end
            end
            ST_REL0: begin
                w_nxt_state = ST_REL1;
            end
            ST_REL1: begin
                w_nxt_state     = ST_RUN;
                w_nxt_lut_valid = 1'b1;
            end
            default: begin
                w_nxt_state   = ST_CLEAR;
                w_nxt_clr_cnt = '0;
            end
        endcase

        case (w_nxt_state)
            ST_RUN: begin
                w_nxt_lookup_hold = 1'b0;
            end
            ST_CLEAR, ST_REL0: begin
                w_nxt_lut_config = 1'b1;
            end
            ST_LOAD: begin
                w_nxt_lut_config = 1'b1;
                w_nxt_waitreq    = 1'b0;
            end
            default: begin
                w_nxt_lut_config = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset restarts a full clear
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state         <= ST_CLEAR;
            r_clr_cnt       <= '0;
            r_idle_cnt      <= '0;
            r_lut_write     <= 1'b0;
            r_lut_address   <= '0;
            r_lut_writedata <= '0;
            r_lut_config    <= 1'b1;
            r_lookup_hold   <= 1'b1;
            r_waitreq       <= 1'b1;
            r_lut_valid     <= 1'b0;
            r_addr_err      <= 1'b0;
        end else begin
            r_state         <= w_nxt_state;
            r_clr_cnt       <= w_nxt_clr_cnt;
            r_idle_cnt      <= w_nxt_idle_cnt;
            r_lut_write     <= w_nxt_lut_write;
            r_lut_address   <= w_nxt_lut_address;
            r_lut_writedata <= w_nxt_lut_writedata;
            r_lut_config    <= w_nxt_lut_config;
            r_lookup_hold   <= w_nxt_lookup_hold;
            r_waitreq       <= w_nxt_waitreq;
            r_lut_valid     <= w_nxt_lut_valid;
            r_addr_err      <= w_nxt_addr_err;
        end
    end

    assign host_lut_waitrequest_o = r_waitreq;
    assign lookup_hold_o          = r_lookup_hold;
    assign lut_config_o           = r_lut_config;
    assign lut_address_o          = r_lut_address;
    assign lut_write_o            = r_lut_write;
    assign lut_writedata_o        = r_lut_writedata;
    assign lut_valid_o            = r_lut_valid;
    assign addr_err_o             = r_addr_err;
    assign state_o                = r_state;

`ifdef HASH_LUT_CTRL_STATS_EN
    logic [31:0] r_wr_cnt, w_nxt_wr_cnt;

    // Saturating count of in-range host writes, zeroed whenever a clear begins
    always_comb begin
        w_nxt_wr_cnt = r_wr_cnt;
        if ((w_nxt_state == ST_CLEAR) && (r_state != ST_CLEAR)) begin
            w_nxt_wr_cnt = '0;
        end else if (w_accept && w_in_range && (r_wr_cnt != '1)) begin
            w_nxt_wr_cnt = r_wr_cnt + 32'd1;
        end
    end

    // Statistics register
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_wr_cnt <= '0;
        end else begin
            r_wr_cnt <= w_nxt_wr_cnt;
        end
    end

    assign wr_cnt_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_hash_lut_cfg_ctrl.sv
// Self-checking bench for hash_lut_cfg_ctrl (TOTAL=32, DRAIN_CYCLES=2).
// Optional feature macro: HASH_LUT_CTRL_STATS_EN enables the wr_cnt_o checks.
`timescale 1ns/1ps
module tb_hash_lut_cfg_ctrl;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned TOTAL = 32;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic          cfg_start_i;
    logic          cfg_commit_i;
    logic [AW-1:0] host_lut_address_i;
    logic          host_lut_write_i;
    logic [DW-1:0] host_lut_writedata_i;
    logic          host_lut_waitrequest_o;
    logic          lookup_busy_i;
    logic          lookup_hold_o;
    logic          lut_config_o;
    logic [AW-1:0] lut_address_o;
    logic          lut_write_o;
    logic [DW-1:0] lut_writedata_o;
    logic          lut_valid_o;
    logic          addr_err_o;
    logic [2:0]    state_o;
`ifdef HASH_LUT_CTRL_STATS_EN
    logic [31:0]   wr_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    hash_lut_cfg_ctrl #(
        .AMM_LUT_ADDR_W (AW),
        .AMM_LUT_DATA_W (DW),
        .MEM_BLOCKS_CNT (2),
        .MEM_BLOCKS_W   (4),
        .DRAIN_CYCLES   (2)
    ) dut (
        .clk_i                  (clk_i),
        .srst_i                 (srst_i),
        .cfg_start_i            (cfg_start_i),
        .cfg_commit_i           (cfg_commit_i),
        .host_lut_address_i     (host_lut_address_i),
        .host_lut_write_i       (host_lut_write_i),
        .host_lut_writedata_i   (host_lut_writedata_i),
        .host_lut_waitrequest_o (host_lut_waitrequest_o),
        .lookup_busy_i          (lookup_busy_i),
        .lookup_hold_o          (lookup_hold_o),
        .lut_config_o           (lut_config_o),
        .lut_address_o          (lut_address_o),
        .lut_write_o            (lut_write_o),
        .lut_writedata_o        (lut_writedata_o),
        .lut_valid_o            (lut_valid_o),
        .addr_err_o             (addr_err_o),
        .state_o                (state_o)
`ifdef HASH_LUT_CTRL_STATS_EN
        ,
        .wr_cnt_o               (wr_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Shadow of the LUT RAM: whatever the controller writes lands here
    logic shadow [TOTAL];
    int   wr_pulses = 0;
    always @(posedge clk_i) begin
        if (lut_write_o) begin
            wr_pulses <= wr_pulses + 1;
            if (lut_address_o < TOTAL) shadow[lut_address_o[4:0]] <= lut_writedata_o[0];
        end
    end

    // Expect a full clear: TOTAL zero writes at ascending addresses, then LOAD
    task automatic run_clear(input string tag);
        for (int i = 0; i < int'(TOTAL); i++) begin
            tick();
            chk({tag, "_wr"},   32'(lut_write_o), 1);
            chk({tag, "_addr"}, lut_address_o, 32'(i));
            chk({tag, "_data"}, lut_writedata_o, 0);
        end
        chk({tag, "_state_load"}, 32'(state_o), 3);
        chk({tag, "_waitreq"},    32'(host_lut_waitrequest_o), 0);
        chk({tag, "_valid"},      32'(lut_valid_o), 0);
        chk({tag, "_config"},     32'(lut_config_o), 1);
    endtask

    typedef struct {
        logic        start, commit, wr, busy;
        logic [31:0] addr, data;
        logic [2:0]  e_state;
        logic        e_wr;
        logic [31:0] e_addr;
        logic        e_cfg, e_hold, e_wait, e_valid;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic c, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic b, input logic [2:0] es,
                                input logic ew, input logic [31:0] ea, input logic ec,
                                input logic eh, input logic ewt, input logic ev);
        vec_t v;
        v.start = s; v.commit = c; v.wr = w; v.addr = a; v.data = d; v.busy = b;
        v.e_state = es; v.e_wr = ew; v.e_addr = ea;
        v.e_cfg = ec; v.e_hold = eh; v.e_wait = ewt; v.e_valid = ev;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[$];
        logic        exp_mem [TOTAL];
        logic        exp_err, commit_sent, w_s, accepted;
        logic [2:0]  s_s, acc_state;
        logic [31:0] a, d;
        int          cyc, nw, base, n_in;

        srst_i = 1'b1; cfg_start_i = 1'b0; cfg_commit_i = 1'b0;
        host_lut_address_i = '0; host_lut_write_i = 1'b0; host_lut_writedata_i = '0;
        lookup_busy_i = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_state",   32'(state_o), 2);
        chk("rst_config",  32'(lut_config_o), 1);
        chk("rst_hold",    32'(lookup_hold_o), 1);
        chk("rst_waitreq", 32'(host_lut_waitrequest_o), 1);
        chk("rst_valid",   32'(lut_valid_o), 0);
        chk("rst_err",     32'(addr_err_o), 0);
        chk("rst_wr",      32'(lut_write_o), 0);
        srst_i = 1'b0;
        run_clear("por_clr");

        // Cycle vectors from LOAD: commit with write, release, drain with busy glitch
        //             st co wr addr data busy | state wr eaddr cfg hold wait valid
        vecs.push_back(mk(1, 1, 1, 5, 1, 0,   3'd4, 1, 5, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   3'd5, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   3'd0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,   3'd0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,   3'd1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,   3'd1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   3'd1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   3'd1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   3'd1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   3'd2, 0, 0, 1, 1, 1, 0));
        foreach (vecs[i]) begin
            cfg_start_i = vecs[i].start; cfg_commit_i = vecs[i].commit;
            host_lut_write_i = vecs[i].wr; host_lut_address_i = vecs[i].addr;
            host_lut_writedata_i = vecs[i].data; lookup_busy_i = vecs[i].busy;
            tick();
            chk($sformatf("vec%0d_state", i),   32'(state_o), 32'(vecs[i].e_state));
            chk($sformatf("vec%0d_wr", i),      32'(lut_write_o), 32'(vecs[i].e_wr));
            if (vecs[i].e_wr) chk($sformatf("vec%0d_addr", i), lut_address_o, vecs[i].e_addr);
            chk($sformatf("vec%0d_config", i),  32'(lut_config_o), 32'(vecs[i].e_cfg));
            chk($sformatf("vec%0d_hold", i),    32'(lookup_hold_o), 32'(vecs[i].e_hold));
            chk($sformatf("vec%0d_waitreq", i), 32'(host_lut_waitrequest_o), 32'(vecs[i].e_wait));
            chk($sformatf("vec%0d_valid", i),   32'(lut_valid_o), 32'(vecs[i].e_valid));
        end
        cfg_start_i = 1'b0; cfg_commit_i = 1'b0; host_lut_write_i = 1'b0; lookup_busy_i = 1'b0;

        // Reset in the middle of the clear restarts it from address 0
        repeat (18) tick();
        chk("midclr_addr", lut_address_o, 17);
        chk("midclr_wr",   32'(lut_write_o), 1);
        srst_i = 1'b1;
        tick();
        chk("midclr_rst_state", 32'(state_o), 2);
        chk("midclr_rst_wr",    32'(lut_write_o), 0);
`ifdef HASH_LUT_CTRL_STATS_EN
        chk("midclr_rst_wrcnt", wr_cnt_o, 0);
`endif
        srst_i = 1'b0;
        run_clear("rst_clr");

        // Out-of-range write is dropped and flags a sticky error
        host_lut_write_i = 1'b1; host_lut_address_i = 40; host_lut_writedata_i = 1;
        tick();
        host_lut_write_i = 1'b0;
        chk("oor_err", 32'(addr_err_o), 1);
        chk("oor_wr",  32'(lut_write_o), 0);
        tick();
        chk("oor_wr_after", 32'(lut_write_o), 0);
        cfg_commit_i = 1'b1; tick(); cfg_commit_i = 1'b0;
        tick(); tick();
        chk("oor_run_state", 32'(state_o), 0);
        chk("oor_err_sticky", 32'(addr_err_o), 1);
        chk("oor_run_valid", 32'(lut_valid_o), 1);

        // Host write issued in RUN stalls until LOAD, then is forwarded exactly once
        host_lut_write_i = 1'b1; host_lut_address_i = 9; host_lut_writedata_i = 1;
        cfg_start_i = 1'b1;
        w_s = host_lut_waitrequest_o;
        tick();
        cfg_start_i = 1'b0;
        chk("stall_first_waitreq", 32'(w_s), 1);
        chk("stall_err_cleared", 32'(addr_err_o), 0);
        chk("stall_drain_hold",  32'(lookup_hold_o), 1);
        accepted = 1'b0; acc_state = 3'd7;
        for (int c = 0; c < 300 && !accepted; c++) begin
            w_s = host_lut_waitrequest_o;
            s_s = state_o;
            tick();
            if (!w_s) begin
                accepted  = 1'b1;
                acc_state = s_s;
            end
        end
        host_lut_write_i = 1'b0;
        chk("stall_accepted",     32'(accepted), 1);
        chk("stall_accept_state", 32'(acc_state), 3);
        chk("stall_fwd_wr",   32'(lut_write_o), 1);
        chk("stall_fwd_addr", lut_address_o, 9);
        chk("stall_fwd_data", lut_writedata_o, 1);
        tick();
        chk("stall_fwd_once", 32'(lut_write_o), 0);
        cfg_commit_i = 1'b1; tick(); cfg_commit_i = 1'b0;
        tick(); tick();
        chk("stall_run_state", 32'(state_o), 0);
        chk("stall_mem9", 32'(shadow[9]), 1);
        chk("stall_mem5_cleared", 32'(shadow[5]), 0);

        // Randomised rounds against a model of the LUT contents
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'(TOTAL); i++) exp_mem[i] = 1'b0;
            exp_err = 1'b0; n_in = 0; commit_sent = 1'b0;
            lookup_busy_i = 1'b1;
            repeat ($urandom_range(1, 5)) tick();
            base = wr_pulses;
            cfg_start_i = 1'b1; tick(); cfg_start_i = 1'b0;
            cyc = 0;
            while (state_o != 3'd3 && cyc < 500) begin
                lookup_busy_i = ($urandom_range(0, 2) == 0);
                tick();
                cyc++;
            end
            lookup_busy_i = 1'b0;
            chk($sformatf("rnd%0d_reach_load", r), 32'(state_o), 3);
            nw = $urandom_range(1, 12);
            for (int k = 0; k < nw; k++) begin
                a = $urandom_range(0, 47);
                d = $urandom;
                repeat ($urandom_range(0, 2)) tick();
                host_lut_write_i = 1'b1; host_lut_address_i = a; host_lut_writedata_i = d;
                cfg_commit_i = (k == nw - 1) && ($urandom_range(0, 1) == 1);
                tick();
                commit_sent = cfg_commit_i;
                host_lut_write_i = 1'b0; cfg_commit_i = 1'b0;
                if (a < TOTAL) begin
                    exp_mem[a[4:0]] = d[0];
                    n_in++;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (!commit_sent) begin
                cfg_commit_i = 1'b1; tick(); cfg_commit_i = 1'b0;
            end
            cyc = 0;
            while (state_o != 3'd0 && cyc < 10) begin
                tick();
                cyc++;
            end
            chk($sformatf("rnd%0d_run", r),   32'(state_o), 0);
            chk($sformatf("rnd%0d_valid", r), 32'(lut_valid_o), 1);
            chk($sformatf("rnd%0d_err", r),   32'(addr_err_o), 32'(exp_err));
            chk($sformatf("rnd%0d_pulses", r), 32'(wr_pulses - base), 32'(int'(TOTAL) + n_in));
            for (int i = 0; i < int'(TOTAL); i++)
                chk($sformatf("rnd%0d_mem%0d", r, i), 32'(shadow[i]), 32'(exp_mem[i]));
`ifdef HASH_LUT_CTRL_STATS_EN
            chk($sformatf("rnd%0d_wrcnt", r), wr_cnt_o, 32'(n_in));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
